pc_ir_unit: RTL and testbench

- Fetch-side register block of the multicycle RV32 core; consumes the controller strobes (PCWrite, IRWrite, AdrSrc, branch, sel_branch) and the ALU flags (zero, lt, bge).
- Owns PC, OldPC, the instruction register (Instr) and the memory data register (Data).
- Generates the unified memory address and the decoded opcode/func3/func7 fields fed back to the controller.
- Adds a sticky misaligned-target trap and a retired-instruction counter.

---
 rtl/pc_ir_unit.sv | 114 +++++++++++
 tb/tb_pc_ir_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pc_ir_unit.sv
// Fetch-side register block of the multicycle RV32 core: PC, OldPC, Instr, Data,
// the unified memory address mux, a sticky misaligned-target trap and instret.
module pc_ir_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             PCWrite,
   input  logic             IRWrite,
   input  logic             AdrSrc,
   input  logic             branch,
   input  logic [1:0]       sel_branch,
   input  logic             zero,
   input  logic             lt,
   input  logic             bge,
   input  logic [31:0]      Result,
   input  logic [31:0]      ReadData,
   output logic [31:0]      Adr,
   output logic [31:0]      PC,
   output logic [31:0]      OldPC,
   output logic [31:0]      Instr,
   output logic [31:0]      Data,
   output logic [6:0]       opcode,
   output logic [2:0]       func3,
   output logic [6:0]       func7,
   output logic             misaligned,
   output logic [31:0]      trap_pc,
   output logic [CNT_W-1:0] instret
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0]      pc_q, pc_d;
   logic [31:0]      old_pc_q, old_pc_d;
   logic [31:0]      instr_q, instr_d;
   logic [31:0]      data_q, data_d;
   logic             misaligned_q, misaligned_d;
   logic [31:0]      trap_pc_q, trap_pc_d;
   logic [CNT_W-1:0] instret_q, instret_d;

   logic cond, taken, pc_load, target_ok, bad_load;

   always_comb begin
      cond = 1'b0;
      unique case (sel_branch)
         2'b00: cond = zero;
         2'b01: cond = ~zero;
         2'b10: cond = lt;
         2'b11: cond = bge;
         default: cond = 1'b0;
      endcase
      taken     = branch & cond;
      pc_load   = PCWrite | taken;
      target_ok = (Result[1:0] == 2'b00);
      bad_load  = pc_load & ~target_ok;
   end

   always_comb begin
      pc_d         = pc_q;
      old_pc_d     = old_pc_q;
      instr_d      = instr_q;
      data_d       = ReadData;
      misaligned_d = misaligned_q | bad_load;
      trap_pc_d    = trap_pc_q;
      instret_d    = instret_q;

      if (pc_load && target_ok)
         pc_d = Result;

      // Only the first bad target is recorded; later ones keep the original cause.
      if (bad_load && !misaligned_q)
         trap_pc_d = old_pc_q;

      if (IRWrite) begin
         instr_d   = ReadData;
         old_pc_d  = pc_q;
         instret_d = instret_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q         <= RESET_PC;
         old_pc_q     <= '0;
         instr_q      <= NOP;
         data_q       <= '0;
         misaligned_q <= 1'b0;
         trap_pc_q    <= '0;
         instret_q    <= '0;
      end else begin
         pc_q         <= pc_d;
         old_pc_q     <= old_pc_d;
         instr_q      <= instr_d;
         data_q       <= data_d;
         misaligned_q <= misaligned_d;
         trap_pc_q    <= trap_pc_d;
         instret_q    <= instret_d;
      end
   end

   assign Adr        = AdrSrc ? Result : pc_q;
   assign PC         = pc_q;
   assign OldPC      = old_pc_q;
   assign Instr      = instr_q;
   assign Data       = data_q;
   assign opcode     = instr_q[6:0];
   assign func3      = instr_q[14:12];
   assign func7      = instr_q[31:25];
   assign misaligned = misaligned_q;
   assign trap_pc    = trap_pc_q;
   assign instret    = instret_q;

endmodule

// File: tb/tb_pc_ir_unit.sv
// Directed bench for pc_ir_unit; a second CNT_W=4 instance shares the stimulus
// so the instret wrap can be observed.
module tb_pc_ir_unit;

   logic        clk = 1'b0;
   logic        rst, PCWrite, IRWrite, AdrSrc, branch, zero, lt, bge;
   logic [1:0]  sel_branch;
   logic [31:0] Result, ReadData;

   logic [31:0] Adr, PC, OldPC, Instr, Data, trap_pc, instret;
   logic [6:0]  opcode, func7;
   logic [2:0]  func3;
   logic        misaligned;

   logic [31:0] Adr4, PC4, OldPC4, Instr4, Data4, trap_pc4;
   logic [6:0]  opcode4, func74;
   logic [2:0]  func34;
   logic        misaligned4;
   logic [3:0]  instret4;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pc_ir_unit dut (
      .clk(clk), .rst(rst), .PCWrite(PCWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
      .branch(branch), .sel_branch(sel_branch), .zero(zero), .lt(lt), .bge(bge),
      .Result(Result), .ReadData(ReadData), .Adr(Adr), .PC(PC), .OldPC(OldPC),
      .Instr(Instr), .Data(Data), .opcode(opcode), .func3(func3), .func7(func7),
      .misaligned(misaligned), .trap_pc(trap_pc), .instret(instret)
   );

   pc_ir_unit #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .PCWrite(PCWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
      .branch(branch), .sel_branch(sel_branch), .zero(zero), .lt(lt), .bge(bge),
      .Result(Result), .ReadData(ReadData), .Adr(Adr4), .PC(PC4), .OldPC(OldPC4),
      .Instr(Instr4), .Data(Data4), .opcode(opcode4), .func3(func34), .func7(func74),
      .misaligned(misaligned4), .trap_pc(trap_pc4), .instret(instret4)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 0; PCWrite = 0; IRWrite = 0; AdrSrc = 0; branch = 0;
      sel_branch = 2'b00; zero = 0; lt = 0; bge = 0;
   endtask

   task automatic load_pc(input logic [31:0] v);
      idle(); PCWrite = 1; Result = v;
      tick();
      idle();
   endtask

   initial begin
      logic [31:0] exp_pc;
      idle(); Result = 0; ReadData = 0;

      // reset
      rst = 1;
      tick();
      idle();
      chk("rst_pc", PC, 32'h0);
      chk("rst_oldpc", OldPC, 32'h0);
      chk("rst_instr", Instr, 32'h0000_0013);
      chk("rst_data", Data, 32'h0);
      chk("rst_mis", {31'b0, misaligned}, 32'h0);
      chk("rst_trap", trap_pc, 32'h0);
      chk("rst_instret", instret, 32'h0);

      // first fetch
      ReadData = 32'h0050_0093; IRWrite = 1; PCWrite = 1; Result = 32'h4;
      #1 chk("fetch_adr", Adr, 32'h0);
      tick();
      idle();
      chk("fetch_pc", PC, 32'h4);
      chk("fetch_oldpc", OldPC, 32'h0);
      chk("fetch_instr", Instr, 32'h0050_0093);
      chk("fetch_opcode", {25'b0, opcode}, 32'h13);
      chk("fetch_func3", {29'b0, func3}, 32'h0);
      chk("fetch_func7", {25'b0, func7}, 32'h0);
      chk("fetch_instret", instret, 32'h1);

      // branch sweep: taken for beq/blt/bge when flags=1, bne when flags=0
      for (int f = 0; f < 2; f++) begin
         for (int s = 0; s < 4; s++) begin
            load_pc(32'h4);
            branch = 1; sel_branch = s[1:0]; Result = 32'h40;
            zero = f[0]; lt = f[0]; bge = f[0];
            tick();
            idle();
            exp_pc = ((s == 1) ? (f == 0) : (f == 1)) ? 32'h40 : 32'h4;
            chk($sformatf("br_sel%0d_f%0d", s, f), PC, exp_pc);
         end
      end

      // branch=0 ignores flags
      load_pc(32'h4);
      sel_branch = 2'b00; zero = 1; lt = 1; bge = 1; Result = 32'h40;
      tick();
      idle();
      chk("nobranch_pc", PC, 32'h4);

      // load path
      AdrSrc = 1; Result = 32'h100; ReadData = 32'hDEAD_BEEF;
      #1 chk("load_adr", Adr, 32'h100);
      tick();
      idle();
      chk("load_data", Data, 32'hDEAD_BEEF);
      chk("load_instr", Instr, 32'h0050_0093);

      // misaligned trap
      load_pc(32'h20);
      IRWrite = 1; PCWrite = 1; Result = 32'h24; ReadData = 32'h0000_0013;
      tick();
      idle();
      chk("mis_oldpc", OldPC, 32'h20);
      PCWrite = 1; Result = 32'h22;
      tick();
      idle();
      chk("mis_pc_hold", PC, 32'h24);
      chk("mis_flag", {31'b0, misaligned}, 32'h1);
      chk("mis_trap", trap_pc, 32'h20);
      IRWrite = 1; PCWrite = 1; Result = 32'h28;
      tick();
      idle();
      chk("mis2_oldpc", OldPC, 32'h24);
      chk("mis2_pc", PC, 32'h28);
      branch = 1; sel_branch = 2'b00; zero = 1; Result = 32'h31;
      tick();
      idle();
      chk("mis2_pc_hold", PC, 32'h28);
      chk("mis2_trap", trap_pc, 32'h20);
      chk("mis2_flag", {31'b0, misaligned}, 32'h1);
      chk("mis_instret", instret, 32'h3);
      rst = 1;
      tick();
      idle();
      chk("mis_rst_flag", {31'b0, misaligned}, 32'h0);
      chk("mis_rst_trap", trap_pc, 32'h0);

      // reset wins over a simultaneous fetch
      IRWrite = 1; PCWrite = 1; Result = 32'h8; ReadData = 32'h1234_5678;
      tick();
      chk("pre_mid_instret", instret, 32'h1);
      rst = 1; Result = 32'hC; ReadData = 32'h0AAA_0AAA;
      tick();
      idle();
      chk("mid_pc", PC, 32'h0);
      chk("mid_oldpc", OldPC, 32'h0);
      chk("mid_instr", Instr, 32'h0000_0013);
      chk("mid_data", Data, 32'h0);
      chk("mid_instret", instret, 32'h0);

      // counter wrap in the 4-bit instance
      IRWrite = 1; ReadData = 32'h0000_0013;
      for (int i = 0; i < 15; i++) tick();
      chk("wrap15", {28'b0, instret4}, 32'hF);
      tick();
      idle();
      chk("wrap16", {28'b0, instret4}, 32'h0);
      chk("nowrap16", instret, 32'h10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
